// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared FSM state type, default widths and counter sizing for the ROM arbiter
package rom_arb_pkg;
  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 14;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first asserted request at or above ptr, wrapping
module rr_pick #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          any_req
);
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p, input int i);
    int j;
    j = 32'(p) + i;
    return PW'(j >= N ? j - N : j);
  endfunction
  assign any_req = |req;
  // scan farthest offset first so the closest request to ptr wins last
  always_comb begin
    grant = ptr;
    for (int i = N - 1; i >= 0; i--)
      if (req[nxt(ptr, i)]) grant = nxt(ptr, i);
  end
endmodule

// File: rtl/rom_rr_arbiter.sv
// rom_rr_arbiter: round-robin sharing of one combinational ROM; response timeout under ROM_ARB_TIMEOUT_EN
module rom_rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_dout,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic                      err_timeout
);
  localparam int PW = $clog2(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_cfg_err
    $error("rom_rr_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC positive");
  end
  state_t state, state_nx;
  logic [PW-1:0] rr_ptr, grant_idx, pick;
  logic any_req, hs, tmo;
  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(pick),
    .any_req(any_req)
  );
  assign hs = state == RESP && rsp_ready[grant_idx];
`ifdef ROM_ARB_TIMEOUT_EN
  localparam int CW = cnt_w(TIMEOUT_CYC);
  logic [CW-1:0] tcnt;
  // held at zero outside RESP, so it starts clean on every RESP entry
  always_ff @(posedge clk) begin
    if (rst || state != RESP) tcnt <= '0;
    else if (!hs && !tmo) tcnt <= tcnt + 1'b1;
  end
  assign tmo = state == RESP && !hs && tcnt == CW'(TIMEOUT_CYC);
`else
  assign tmo = 1'b0;
`endif
  assign err_timeout = tmo;
  assign busy = state != IDLE;
  assign req_ready = (state == IDLE && any_req) ? NUM_REQ'(1) << pick : '0;
  assign rsp_valid = (state == RESP && !tmo) ? NUM_REQ'(1) << grant_idx : '0;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (any_req ? READ : IDLE) :
               state == READ ? RESP :
               (hs || tmo) ? IDLE : RESP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_idx <= '0;
      rom_addr <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        grant_idx <= pick;
        rom_addr <= req_addr[pick*ADDR_W +: ADDR_W];
      end
      if (state == READ) rsp_data <= rom_dout;
      if (hs || tmo) rr_ptr <= grant_idx == PW'(NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_rom_rr_arbiter.sv
// tb_rom_rr_arbiter: table-driven per-cycle checks plus reset and response-wait sequences
module tb_rom_rr_arbiter;
  logic clk = 0;
  logic rst;
  logic [3:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] req_addr;
  logic [1:0] rom_addr;
  logic [13:0] rom_dout, rsp_data;
  logic busy, err_timeout;
  int pass_cnt = 0, total = 0;

  always #5 clk = ~clk;
  assign rom_dout = 14'h1000 | {12'b0, rom_addr};

  rom_rr_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rom_addr(rom_addr), .rom_dout(rom_dout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy), .err_timeout(err_timeout)
  );

  typedef struct {
    logic rst;
    logic [3:0] rv;
    logic [7:0] ra;
    logic [3:0] rr;
    logic [3:0] erdy;
    logic [3:0] evld;
    logic [13:0] edat;
    logic ebusy;
  } vec_t;
  vec_t tv[$];

  task automatic t(input logic r, input logic [3:0] rv, input logic [7:0] ra, input logic [3:0] rr,
                   input logic [3:0] erdy, input logic [3:0] evld, input logic [13:0] edat, input logic eb);
    vec_t v;
    v.rst = r; v.rv = rv; v.ra = ra; v.rr = rr;
    v.erdy = erdy; v.evld = evld; v.edat = edat; v.ebusy = eb;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // single request, addr 2
    t(0, 4'b0001, 8'h02, 4'b0000, 4'b0001, 4'b0000, 14'h0000, 0);
    t(0, 4'b0000, 8'h02, 4'b0000, 4'b0000, 4'b0000, 14'h0000, 1);
    t(0, 4'b0000, 8'h02, 4'b0001, 4'b0000, 4'b0001, 14'h1002, 1);
    t(0, 4'b0000, 8'h02, 4'b0000, 4'b0000, 4'b0000, 14'h1002, 0);
    // reset, then all four requesting with rsp_ready high
    t(1, 4'b0000, 8'he4, 4'b0000, 4'b0000, 4'b0000, 14'h1002, 0);
    t(0, 4'b1111, 8'he4, 4'b1111, 4'b0001, 4'b0000, 14'h0000, 0);
    t(0, 4'b1111, 8'he4, 4'b1111, 4'b0000, 4'b0000, 14'h0000, 1);
    t(0, 4'b1111, 8'he4, 4'b1111, 4'b0000, 4'b0001, 14'h1000, 1);
    t(0, 4'b1111, 8'he4, 4'b1111, 4'b0010, 4'b0000, 14'h1000, 0);
    t(0, 4'b1111, 8'he4, 4'b1111, 4'b0000, 4'b0000, 14'h1000, 1);
    t(0, 4'b1111, 8'he4, 4'b1111, 4'b0000, 4'b0010, 14'h1001, 1);
    t(0, 4'b1111, 8'he4, 4'b1111, 4'b0100, 4'b0000, 14'h1001, 0);
    t(0, 4'b1111, 8'he4, 4'b1111, 4'b0000, 4'b0000, 14'h1001, 1);
    t(0, 4'b1111, 8'he4, 4'b1111, 4'b0000, 4'b0100, 14'h1002, 1);
    t(0, 4'b1111, 8'he4, 4'b1111, 4'b1000, 4'b0000, 14'h1002, 0);
    t(0, 4'b1111, 8'he4, 4'b1111, 4'b0000, 4'b0000, 14'h1002, 1);
    t(0, 4'b1111, 8'he4, 4'b1111, 4'b0000, 4'b1000, 14'h1003, 1);
    t(0, 4'b1111, 8'he4, 4'b1111, 4'b0001, 4'b0000, 14'h1003, 0);
    t(0, 4'b1111, 8'he4, 4'b1111, 4'b0000, 4'b0000, 14'h1003, 1);
    t(0, 4'b1111, 8'he4, 4'b1111, 4'b0000, 4'b0001, 14'h1000, 1);
    // back-pressure on requester 1 with requester 2 waiting; other rsp_ready bits ignored
    t(0, 4'b0110, 8'he4, 4'b0000, 4'b0010, 4'b0000, 14'h1000, 0);
    t(0, 4'b0110, 8'he4, 4'b0000, 4'b0000, 4'b0000, 14'h1000, 1);
    for (int i = 0; i < 5; i++) t(0, 4'b0110, 8'he4, 4'b1101, 4'b0000, 4'b0010, 14'h1001, 1);
    t(0, 4'b0110, 8'he4, 4'b0010, 4'b0000, 4'b0010, 14'h1001, 1);
    t(0, 4'b0110, 8'he4, 4'b0000, 4'b0100, 4'b0000, 14'h1001, 0);
    t(0, 4'b0000, 8'he4, 4'b0000, 4'b0000, 4'b0000, 14'h1001, 1);
    t(0, 4'b0000, 8'he4, 4'b0000, 4'b0000, 4'b0100, 14'h1002, 1);
    // reset while rsp_valid[2] is high
    t(1, 4'b0000, 8'he4, 4'b0000, 4'b0000, 4'b0100, 14'h1002, 1);
    t(0, 4'b0000, 8'he4, 4'b0000, 4'b0000, 4'b0000, 14'h0000, 0);
    t(0, 4'b1000, 8'he4, 4'b0000, 4'b1000, 4'b0000, 14'h0000, 0);
    t(0, 4'b0000, 8'he4, 4'b0000, 4'b0000, 4'b0000, 14'h0000, 1);
    t(0, 4'b0000, 8'he4, 4'b1000, 4'b0000, 4'b1000, 14'h1003, 1);
    // after serving 3, requesters 0 and 3 together: 0 first; then ptr=1 picks 3
    t(0, 4'b1001, 8'he4, 4'b0000, 4'b0001, 4'b0000, 14'h1003, 0);
    t(0, 4'b1000, 8'he4, 4'b0000, 4'b0000, 4'b0000, 14'h1003, 1);
    t(0, 4'b1000, 8'he4, 4'b1111, 4'b0000, 4'b0001, 14'h1000, 1);
    t(0, 4'b1001, 8'he4, 4'b0000, 4'b1000, 4'b0000, 14'h1000, 0);
    t(0, 4'b0000, 8'he4, 4'b0000, 4'b0000, 4'b0000, 14'h1000, 1);
    t(0, 4'b0000, 8'he4, 4'b1000, 4'b0000, 4'b1000, 14'h1003, 1);
    t(0, 4'b0000, 8'he4, 4'b0000, 4'b0000, 4'b0000, 14'h1003, 0);

    rst = 1; req_valid = 0; req_addr = 0; rsp_ready = 0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("reset_req_ready", -1, 32'(req_ready), 0);
    chk("reset_rsp_valid", -1, 32'(rsp_valid), 0);
    chk("reset_rsp_data", -1, 32'(rsp_data), 0);
    chk("reset_rom_addr", -1, 32'(rom_addr), 0);
    chk("reset_busy", -1, 32'(busy), 0);
    chk("reset_err_timeout", -1, 32'(err_timeout), 0);
    next_cycle();

    foreach (tv[i]) begin
      rst = tv[i].rst; req_valid = tv[i].rv; req_addr = tv[i].ra; rsp_ready = tv[i].rr;
      @(negedge clk);
      chk("req_ready", i, 32'(req_ready), 32'(tv[i].erdy));
      chk("rsp_valid", i, 32'(rsp_valid), 32'(tv[i].evld));
      chk("rsp_data", i, 32'(rsp_data), 32'(tv[i].edat));
      chk("busy", i, 32'(busy), 32'(tv[i].ebusy));
      chk("err_timeout", i, 32'(err_timeout), 0);
      next_cycle();
    end

    // reset during READ drops the transaction
    rst = 0; rsp_ready = 0; req_valid = 4'b0100; req_addr = 8'he4;
    @(negedge clk);
    chk("rd_rst_accept", 0, 32'(req_ready), 32'(4'b0100));
    next_cycle();
    req_valid = 0; rst = 1;
    @(negedge clk);
    chk("rd_rst_busy_before", 0, 32'(busy), 1);
    next_cycle();
    rst = 0;
    @(negedge clk);
    chk("rd_rst_busy_after", 0, 32'(busy), 0);
    chk("rd_rst_rsp_valid", 0, 32'(rsp_valid), 0);
    chk("rd_rst_rsp_data", 0, 32'(rsp_data), 0);
    next_cycle();

    // response left unacknowledged
    req_valid = 4'b0001;
    @(negedge clk);
    chk("wait_accept", 0, 32'(req_ready), 32'(4'b0001));
    next_cycle();
    req_valid = 0;
`ifdef ROM_ARB_TIMEOUT_EN
    begin
      int n = 0;
      logic done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge clk);
        if (err_timeout) begin
          done = 1;
          chk("tmo_rsp_valid_drop", c, 32'(rsp_valid), 0);
        end else if (rsp_valid == 4'b0001) n++;
        next_cycle();
      end
      chk("tmo_seen", 0, 32'(done), 1);
      chk("tmo_valid_cycles", 0, n, 15);
      req_valid = 4'b0011;
      @(negedge clk);
      chk("tmo_busy_after", 0, 32'(busy), 0);
      chk("tmo_next_grant", 0, 32'(req_ready), 32'(4'b0010));
      next_cycle();
      req_valid = 0;
    end
`else
    for (int c = 0; c < 20; c++) next_cycle();
    @(negedge clk);
    chk("hold_rsp_valid", 0, 32'(rsp_valid), 32'(4'b0001));
    chk("hold_rsp_data", 0, 32'(rsp_data), 32'(14'h1000));
    chk("hold_busy", 0, 32'(busy), 1);
    chk("hold_err_timeout", 0, 32'(err_timeout), 0);
    next_cycle();
    rsp_ready = 4'b0001;
    next_cycle();
    rsp_ready = 0; req_valid = 4'b0011;
    @(negedge clk);
    chk("hold_next_grant", 0, 32'(req_ready), 32'(4'b0010));
    next_cycle();
    req_valid = 0;
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/rom_rr_arbiter.md
Name: rom_rr_arbiter

Overview:
Shares one combinational parametrizable ROM (address in, data out, no clock) between NUM_REQ requesters. Each requester issues an address with a valid/ready handshake. The block grants one requester at a time using round-robin priority, registers the ROM address, captures the ROM word, and returns it to the granted requester with a valid/ready handshake. It sits between the ROM instance and its client blocks.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 2, ROM address width
DATA_W, 14, ROM data width
TIMEOUT_CYC, 15, response wait limit in cycles; used only with ROM_ARB_TIMEOUT_EN

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester read request
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester k occupies bits [k*ADDR_W +: ADDR_W]
req_ready  out  NUM_REQ  one-hot accept pulse
rom_addr  out  ADDR_W  registered address to the ROM
rom_dout  in  DATA_W  ROM data (combinational from rom_addr)
rsp_valid  out  NUM_REQ  one-hot response valid
rsp_ready  in  NUM_REQ  per-requester response accept
rsp_data  out  DATA_W  registered ROM word
busy  out  1  high in any state except IDLE
err_timeout  out  1  one-cycle timeout pulse (always 0 when the feature is compiled out)

Behaviour:
- Reset (rst=1 at a clk edge), from any state including mid-transaction: state=IDLE, rr_ptr=0, rom_addr=0, rsp_data=0. req_ready, rsp_valid, busy and err_timeout are all 0. Any in-flight transaction is dropped silently.
- FSM states: IDLE, READ, RESP.
- IDLE:
  - If req_valid is nonzero, the grant goes to the first asserted index searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - In the same cycle: req_ready[grant]=1 (combinational, single cycle); rom_addr and grant_idx are registered at the edge; next state is READ.
  - If req_valid is zero: stay in IDLE, all outputs 0.
- READ (one cycle): rom_dout has settled from the registered rom_addr. rsp_data <= rom_dout; next state is RESP.
- RESP:
  - rsp_valid[grant_idx]=1; rsp_data is held stable.
  - When rsp_ready[grant_idx]=1: the handshake completes at that edge, rr_ptr <= (grant_idx+1) mod NUM_REQ, next state is IDLE.
  - rsp_ready on any other index is ignored.
- Latency: accept at cycle N, rsp_valid at cycle N+2; minimum 3 cycles per transaction; at most one transaction outstanding.
- req_ready is never asserted outside IDLE. Requests arriving in READ or RESP wait; a requester must hold req_valid and req_addr until req_ready.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 grants to other clients.
- Simultaneous requests: resolved purely by rr_ptr. Example: rr_ptr=2 with requesters 1 and 3 active grants 3.
- rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
Macro ROM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on RESP entry and increments each RESP cycle without rsp_ready[grant_idx].
  - When it reaches TIMEOUT_CYC: err_timeout pulses high for 1 cycle, rsp_valid drops, rr_ptr advances as if the handshake completed, state goes to IDLE.
- Undefined: no counter; RESP waits indefinitely; err_timeout is tied to 0.

Decomposition:
- Package rom_arb_pkg: state enum type (IDLE, READ, RESP); default width constants ADDR_W_DEF=2, DATA_W_DEF=14; TIMEOUT counter width function (clog2).
- Sub-module rr_pick (combinational): inputs req vector and rr_ptr; outputs grant index and any_req. The top module holds the FSM, registers and timeout logic.

Test Plan:
- Bench ROM model returns rom_dout = 14'h1000 | rom_addr.
- Single request: req_valid=4'b0001, req_addr[0]=2'd2 -> req_ready[0] pulses in cycle 0; rsp_valid[0]=1 at cycle 2 with rsp_data=14'h1002; rsp_ready[0]=1 -> IDLE, busy=0 next cycle.
- All four requesting continuously, each with addr = its index, rsp_ready tied high -> grant order 0,1,2,3,0; rsp_data sequence 14'h1000, 14'h1001, 14'h1002, 14'h1003, 14'h1000; one grant every 3 cycles.
- Back-pressure: rsp_ready[1] held low 5 cycles -> rsp_valid[1] and rsp_data stay stable; req_ready stays 0 for requester 2 throughout.
- Reset in RESP: assert rst for 1 cycle while rsp_valid[2]=1 -> next cycle all outputs 0, rr_ptr=0; a new request from requester 3 is granted normally.
- Priority wrap: after serving requester 3, assert requesters 0 and 3 together -> requester 0 is granted first.
- With ROM_ARB_TIMEOUT_EN, TIMEOUT_CYC=15, rsp_ready held 0 -> err_timeout pulses 15 cycles after RESP entry; rsp_valid falls; the next grant goes to the following index.
